// File: rtl/fc_layer_if.sv
// Bus bundle for fc_layer: input vector stream, weight memory read port and result stream.
// The slave modport is the layer's view; master is the surrounding fabric's view.
interface fc_layer_if #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned POOL_PIXEL_COUNT = 16,
  parameter int unsigned NUM_NEURONS      = 10,
  parameter int unsigned ACC_WIDTH        = 32
);
  localparam int unsigned ADDR_WIDTH =
    (NUM_NEURONS * (POOL_PIXEL_COUNT + 1) > 1) ? $clog2(NUM_NEURONS * (POOL_PIXEL_COUNT + 1)) : 1;
  localparam int unsigned NEURON_WIDTH = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  logic [DATA_WIDTH-1:0]        flatten_in [POOL_PIXEL_COUNT];
  logic                         in_valid;
  logic                         in_ready;
  logic                         w_en;
  logic [ADDR_WIDTH-1:0]        w_addr;
  logic signed [DATA_WIDTH-1:0] w_data;
  logic signed [ACC_WIDTH-1:0]  out_data;
  logic [NEURON_WIDTH-1:0]      out_neuron;
  logic                         out_last;
  logic                         out_valid;
  logic                         out_ready;

  modport slave (
    input  flatten_in, in_valid, w_data, out_ready,
    output in_ready, w_en, w_addr, out_data, out_neuron, out_last, out_valid
  );

  modport master (
    output flatten_in, in_valid, w_data, out_ready,
    input  in_ready, w_en, w_addr, out_data, out_neuron, out_last, out_valid
  );
endinterface

// File: rtl/fc_layer.sv
// Dense layer with one time-shared MAC: per neuron, P weight reads plus a bias read,
// accumulated into a wrapping accumulator and emitted over a valid/ready stream.
module fc_layer #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned POOL_PIXEL_COUNT = 16,
  parameter int unsigned NUM_NEURONS      = 10,
  parameter int unsigned ACC_WIDTH        = 32
) (
  input logic     clk,
  input logic     rst_n,
  fc_layer_if.slave bus
);
  localparam int unsigned P          = POOL_PIXEL_COUNT;
  localparam int unsigned N          = NUM_NEURONS;
  localparam int unsigned ADDR_WIDTH = (N * (P + 1) > 1) ? $clog2(N * (P + 1)) : 1;
  localparam int unsigned NW         = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW         = $clog2(P + 1);
  localparam int unsigned PW         = 2 * DATA_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, EMIT} state_t;

  state_t                      state_q, state_d;
  logic [DATA_WIDTH-1:0]       act_q [P];
  logic [DATA_WIDTH-1:0]       act_d [P];
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [NW-1:0]               neuron_q, neuron_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        in_ready_q, in_ready_d;
  logic                        w_en_q, w_en_d;
  logic [ADDR_WIDTH-1:0]       w_addr_q, w_addr_d;
  logic                        out_valid_q, out_valid_d;
  logic signed [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic [NW-1:0]               out_neuron_q, out_neuron_d;
  logic                        out_last_q, out_last_d;

  logic [DATA_WIDTH-1:0]       act_sel;
  logic signed [PW-1:0]        act_ext;
  logic signed [PW-1:0]        wd_ext;
  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] bias_sum;

  assign bus.in_ready   = in_ready_q;
  assign bus.w_en       = w_en_q;
  assign bus.w_addr     = w_addr_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_neuron = out_neuron_q;
  assign bus.out_last   = out_last_q;

  // Data arriving now belongs to the read issued last cycle, i.e. activation cnt-1.
  always_comb begin
    act_sel = '0;
    for (int unsigned i = 0; i < P; i++) begin
      if (cnt_q == CW'(i + 1)) act_sel = act_q[i];
    end
  end

  assign act_ext  = PW'({1'b0, act_sel});
  assign wd_ext   = PW'(bus.w_data);
  assign prod     = act_ext * wd_ext;
  assign bias_sum = acc_q + ACC_WIDTH'(bus.w_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      act_q        <= '{default: '0};
      cnt_q        <= '0;
      neuron_q     <= '0;
      acc_q        <= '0;
      in_ready_q   <= 1'b1;
      w_en_q       <= 1'b0;
      w_addr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_neuron_q <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      cnt_q        <= cnt_d;
      neuron_q     <= neuron_d;
      acc_q        <= acc_d;
      in_ready_q   <= in_ready_d;
      w_en_q       <= w_en_d;
      w_addr_q     <= w_addr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_neuron_q <= out_neuron_d;
      out_last_q   <= out_last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    act_d        = act_q;
    cnt_d        = cnt_q;
    neuron_d     = neuron_q;
    acc_d        = acc_q;
    in_ready_d   = in_ready_q;
    w_en_d       = w_en_q;
    w_addr_d     = w_addr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_neuron_d = out_neuron_q;
    out_last_d   = out_last_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          act_d      = bus.flatten_in;
          cnt_d      = '0;
          neuron_d   = '0;
          acc_d      = '0;
          in_ready_d = 1'b0;
          w_en_d     = 1'b1;
          w_addr_d   = '0;
          state_d    = MAC;
        end
      end
      MAC: begin
        if (cnt_q != '0) acc_d = acc_q + ACC_WIDTH'(prod);
        if (cnt_q == CW'(P)) begin
          w_en_d  = 1'b0;
          state_d = DRAIN;
        end else begin
          cnt_d    = cnt_q + CW'(1);
          w_addr_d = w_addr_q + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        acc_d        = bias_sum;
        out_data_d   = bias_sum;
        out_valid_d  = 1'b1;
        out_neuron_d = neuron_q;
        out_last_d   = (neuron_q == NW'(N - 1));
        state_d      = EMIT;
      end
      EMIT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (neuron_q == NW'(N - 1)) begin
            in_ready_d = 1'b1;
            w_addr_d   = '0;
            state_d    = IDLE;
          end else begin
            // Next neuron's base directly follows this neuron's bias word.
            neuron_d = neuron_q + NW'(1);
            cnt_d    = '0;
            acc_d    = '0;
            w_en_d   = 1'b1;
            w_addr_d = w_addr_q + ADDR_WIDTH'(1);
            state_d  = MAC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fc_layer.sv
// Self-checking bench for fc_layer: weight memory model, arithmetic scoreboard,
// and directed vectors covering baseline, signed extremes, backpressure and reset.
module tb_fc_layer;
  localparam int unsigned DW  = 8;
  localparam int unsigned P   = 5;
  localparam int unsigned N   = 4;
  localparam int unsigned ACC = 32;
  localparam int unsigned MW  = N * (P + 1);

  typedef struct {
    longint data;
    int     neuron;
    bit     last;
  } exp_t;

  logic clk;
  logic rst_n;

  fc_layer_if #(.DATA_WIDTH(DW), .POOL_PIXEL_COUNT(P), .NUM_NEURONS(N), .ACC_WIDTH(ACC)) bus ();

  fc_layer #(.DATA_WIDTH(DW), .POOL_PIXEL_COUNT(P), .NUM_NEURONS(N), .ACC_WIDTH(ACC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [DW-1:0] mem [MW];
  int            act_vec [P];
  exp_t          q [$];
  longint        got [N];
  int            total = 0;
  int            bad = 0;
  int            n_acc = 0;
  int            cyc = 0;
  int            last_evt = 0;
  int            exp_addr = 0;
  bit            seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Weight memory: read data appears one cycle after the strobe.
  always @(posedge clk) if (bus.w_en) bus.w_data <= mem[bus.w_addr];

  task automatic chk(input string name, input longint actual, input longint expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: plain dot products over the captured vector and the memory image.
  task automatic push_model();
    for (int n = 0; n < N; n++) begin
      longint a;
      exp_t   e;
      a = 0;
      for (int k = 0; k < P; k++)
        a += longint'(bus.flatten_in[k]) * longint'($signed(mem[n*(P+1)+k]));
      a += longint'($signed(mem[n*(P+1)+P]));
      e.data   = longint'($signed(a[31:0]));
      e.neuron = n;
      e.last   = (n == N - 1);
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      seen     = 0;
      exp_addr = 0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        push_model();
        exp_addr = 0;
        last_evt = cyc;
      end
      if (bus.w_en) begin
        chk("w_addr_seq", longint'(bus.w_addr), exp_addr);
        exp_addr++;
      end
      if (bus.out_valid) begin
        chk("emit_w_en", longint'(bus.w_en), 0);
        chk("emit_in_ready", longint'(bus.in_ready), 0);
        if (q.size() == 0) begin
          chk("unexpected_out_valid", longint'(bus.out_valid), 0);
        end else begin
          chk("out_data", longint'(bus.out_data), q[0].data);
          chk("out_neuron", longint'(bus.out_neuron), q[0].neuron);
          chk("out_last", longint'(bus.out_last), longint'(q[0].last));
          if (!seen) chk("valid_latency", cyc - last_evt, P + 3);
          seen = 1;
          if (bus.out_ready) begin
            got[q[0].neuron] = longint'(bus.out_data);
            void'(q.pop_front());
            n_acc++;
            last_evt = cyc;
            seen     = 0;
          end
        end
      end
    end
  end

  task automatic load(input int mode);
    for (int n = 0; n < N; n++) begin
      for (int k = 0; k < P; k++) begin
        case (mode)
          1: mem[n*(P+1)+k] = DW'(1);
          2: mem[n*(P+1)+k] = 8'h80;
          default: mem[n*(P+1)+k] = DW'(n + 1);
        endcase
      end
      case (mode)
        1: mem[n*(P+1)+P] = DW'(0);
        2: mem[n*(P+1)+P] = 8'hFF;
        default: mem[n*(P+1)+P] = DW'(n);
      endcase
    end
    for (int k = 0; k < P; k++) begin
      case (mode)
        1: act_vec[k] = 1;
        2: act_vec[k] = 255;
        default: act_vec[k] = k % 4;
      endcase
    end
    for (int n = 0; n < N; n++) got[n] = -999999;
  endtask

  task automatic send_vec();
    in_drive(1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < P; k++) bus.flatten_in[k] = 8'hAA;
  endtask

  task automatic in_drive(input bit v);
    bus.in_valid = v;
    for (int k = 0; k < P; k++) bus.flatten_in[k] = DW'(act_vec[k]);
  endtask

  task automatic run_vec(input int stall_neuron);
    int  base;
    bit  stalled;
    base    = n_acc;
    stalled = 0;
    send_vec();
    for (int i = 0; i < 2000 && n_acc < base + N; i++) begin
      if (stall_neuron >= 0 && !stalled && bus.out_valid && int'(bus.out_neuron) == stall_neuron) begin
        bus.out_ready = 1'b0;
        stalled = 1;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk); #1;
          chk("stall_w_en", longint'(bus.w_en), 0);
          chk("stall_valid", longint'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("result_count", n_acc - base, N);
    chk("in_ready_after", longint'(bus.in_ready), 1);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.w_data    = '0;
    for (int k = 0; k < P; k++) bus.flatten_in[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    chk("rst_w_en", longint'(bus.w_en), 0);
    chk("rst_w_addr", longint'(bus.w_addr), 0);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_data", longint'(bus.out_data), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All-ones baseline: every neuron sums to P.
    load(1);
    run_vec(-1);
    for (int n = 0; n < N; n++) chk("t1_value", got[n], 5);

    // Signed extremes: 255 * -128 * 5 - 1.
    load(2);
    run_vec(-1);
    chk("t2_first", got[0], -163201);
    chk("t2_last", got[N-1], -163201);

    // Distinct per-neuron data: (n+1)*6 + n.
    load(3);
    run_vec(-1);
    chk("t3_n0", got[0], 6);
    chk("t3_n1", got[1], 13);
    chk("t3_n2", got[2], 20);
    chk("t3_n3", got[3], 27);
    chk("t3_addr_span", exp_addr, MW);

    // Backpressure on neuron 2.
    load(1);
    run_vec(2);
    for (int n = 0; n < N; n++) chk("t4_value", got[n], 5);

    // Busy input pulse, then reset during neuron 1.
    begin
      int base;
      load(1);
      base = n_acc;
      send_vec();
      @(posedge clk); #1;
      for (int k = 0; k < P; k++) act_vec[k] = 7;
      in_drive(1'b1);
      chk("busy_in_ready", longint'(bus.in_ready), 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 200 && n_acc < base + 1; i++) @(posedge clk);
      chk("t5_first_result", n_acc - base, 1);
      chk("t5_no_recapture", got[0], 5);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", longint'(bus.in_ready), 1);
      chk("mid_rst_w_en", longint'(bus.w_en), 0);
      chk("mid_rst_w_addr", longint'(bus.w_addr), 0);
      chk("mid_rst_out_valid", longint'(bus.out_valid), 0);
      chk("mid_rst_out_data", longint'(bus.out_data), 0);
      chk("mid_rst_out_neuron", longint'(bus.out_neuron), 0);
      chk("mid_rst_out_last", longint'(bus.out_last), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("post_rst_idle_valid", longint'(bus.out_valid), 0);
      chk("post_rst_idle_ready", longint'(bus.in_ready), 1);
    end
    load(3);
    run_vec(-1);
    chk("t5_n0", got[0], 6);
    chk("t5_n1", got[1], 13);
    chk("t5_n2", got[2], 20);
    chk("t5_n3", got[3], 27);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
